// File: rtl/fire_expand_conv_engine.sv
// Layer-selectable KDIM x KDIM expand convolution: streams one tap per handshake,
// accumulates CHOUT channels in parallel, then emits a biased, ReLU'd, saturated pixel.
module fire_expand_conv_engine #(
    parameter int WIDTH      = 16,
    parameter int CHIN       = 16,
    parameter int CHOUT      = 64,
    parameter int KDIM       = 3,
    parameter int WOUT       = 64,
    parameter int NUM_LAYERS = 2,
    parameter int FRAC       = 14
) (
    input  logic                                                            clk,
    input  logic                                                            rst,
    input  logic                                                            start,
    input  logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0]          layer_sel,
    output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0]          layer_out,
    output logic                                                            busy,
    output logic                                                            done,
    input  logic                                                            ifm_valid,
    output logic                                                            ifm_ready,
    input  logic [WIDTH-1:0]                                                ifm_data,
    output logic [((KDIM*KDIM*CHIN > 1) ? $clog2(KDIM*KDIM*CHIN) : 1)-1:0]  w_addr,
    input  logic [CHOUT*WIDTH-1:0]                                          w_data,
    input  logic [CHOUT*2*WIDTH-1:0]                                        bias_data,
    output logic                                                            ofm_valid,
    input  logic                                                            ofm_ready,
    output logic [CHOUT*WIDTH-1:0]                                          ofm_data
);

    localparam int TAPS   = KDIM * KDIM * CHIN;
    localparam int NPIX   = WOUT * WOUT;
    localparam int LSEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int ACC_W  = 2 * WIDTH + $clog2(TAPS) + 1;

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1'b1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1'b1);
    localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_EXT = {{(ACC_W-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        OUT   = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   next_s;
    logic [TAP_W-1:0]         tap_cnt_r;
    logic [PIX_W-1:0]         pix_cnt_r;
    logic signed [ACC_W-1:0]  acc_r   [CHOUT];
    logic signed [2*WIDTH-1:0] prod_s [CHOUT];
    logic signed [ACC_W:0]    sum_s   [CHOUT];
    logic [LSEL_W-1:0]        layer_clamp_s;
    logic [LSEL_W-1:0]        layer_out_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     ifm_ready_r;
    logic                     ofm_valid_r;
    logic [CHOUT*WIDTH-1:0]   ofm_data_r;
    logic                     tap_hs_s;
    logic                     ofm_hs_s;

    // Negative sums are clipped to zero before the shift; positive overflow clips to max.
    function automatic logic [WIDTH-1:0] relu_sat(input logic signed [ACC_W:0] s);
        logic signed [ACC_W:0] sh;
        sh = s >>> FRAC;
        if (s[ACC_W]) begin
            relu_sat = '0;
        end else if (sh > SAT_EXT) begin
            relu_sat = SAT_MAX;
        end else begin
            relu_sat = sh[WIDTH-1:0];
        end
    endfunction

    assign layer_out = layer_out_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign ifm_ready = ifm_ready_r;
    assign ofm_valid = ofm_valid_r;
    assign ofm_data  = ofm_data_r;
    assign w_addr    = tap_cnt_r;

    // Handshakes, per-channel products and biased sums.
    always_comb begin
        tap_hs_s = (state_r == ACCUM) && ifm_valid;
        ofm_hs_s = (state_r == HOLD) && ofm_ready;
        if (32'(layer_sel) >= NUM_LAYERS) begin
            layer_clamp_s = '0;
        end else begin
            layer_clamp_s = layer_sel;
        end
        for (int c = 0; c < CHOUT; c++) begin
            prod_s[c] = $signed(ifm_data) * $signed(w_data[c*WIDTH +: WIDTH]);
            sum_s[c]  = (ACC_W+1)'(acc_r[c]) + (ACC_W+1)'($signed(bias_data[c*2*WIDTH +: 2*WIDTH]));
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_s = ACCUM;
                else       next_s = IDLE;
            end
            ACCUM: begin
                if (tap_hs_s && (tap_cnt_r == TAP_LAST)) next_s = OUT;
                else                                      next_s = ACCUM;
            end
            OUT: next_s = HOLD;
            HOLD: begin
                if (!ofm_hs_s)                    next_s = HOLD;
                else if (pix_cnt_r == PIX_LAST)   next_s = DONE;
                else                              next_s = ACCUM;
            end
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= next_s;
    end

    // Status flags follow the state being entered so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ifm_ready_r <= 1'b0;
        end else begin
            busy_r      <= (next_s == ACCUM) || (next_s == OUT) || (next_s == HOLD);
            done_r      <= (next_s == DONE);
            ifm_ready_r <= (next_s == ACCUM);
        end
    end

    // Counters, accumulators and the output pixel register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_out_r <= '0;
            tap_cnt_r   <= '0;
            pix_cnt_r   <= '0;
            ofm_valid_r <= 1'b0;
            ofm_data_r  <= '0;
            for (int c = 0; c < CHOUT; c++) acc_r[c] <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        layer_out_r <= layer_clamp_s;
                        tap_cnt_r   <= '0;
                        pix_cnt_r   <= '0;
                        for (int c = 0; c < CHOUT; c++) acc_r[c] <= '0;
                    end
                end
                ACCUM: begin
                    if (tap_hs_s) begin
                        tap_cnt_r <= tap_cnt_r + TAP_ONE;
                        for (int c = 0; c < CHOUT; c++) acc_r[c] <= acc_r[c] + ACC_W'(prod_s[c]);
                    end
                end
                OUT: begin
                    ofm_valid_r <= 1'b1;
                    for (int c = 0; c < CHOUT; c++) begin
                        ofm_data_r[c*WIDTH +: WIDTH] <= relu_sat(sum_s[c]);
                        acc_r[c] <= '0;
                    end
                end
                HOLD: begin
                    if (ofm_hs_s) begin
                        ofm_valid_r <= 1'b0;
                        pix_cnt_r   <= pix_cnt_r + PIX_ONE;
                        tap_cnt_r   <= '0;
                    end
                end
                DONE: begin
                    tap_cnt_r <= '0;
                end
                default: begin
                    ofm_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fire_expand_conv_engine.md
Name: fire_expand_conv_engine

Overview:
- Parametrised, layer-selectable 3x3 (KDIM x KDIM) expand-convolution engine for the squeeze/expand fire stages.
- Computes CHOUT output channels in parallel, one output pixel at a time, from a streamed IFM and a combinational per-layer weight ROM.
- Successor to the fixed two-layer expand engine. Adds N-layer select, ifm/ofm valid-ready handshakes with stall/backpressure, configurable fixed-point shift, saturating ReLU and an explicit start/busy/done protocol.

Parameters:
- WIDTH, 16, pixel/weight/output word width (signed fixed point).
- CHIN, 16, input channels.
- CHOUT, 64, output channels (parallel MACs).
- KDIM, 3, kernel window dimension.
- WOUT, 64, output feature-map side; WOUT*WOUT pixels per layer.
- NUM_LAYERS, 2, number of selectable layers (weight/bias sets).
- FRAC, 14, right shift applied to the biased accumulator before output.
- Derived: TAPS = KDIM*KDIM*CHIN; LSEL_W = max(1, $clog2(NUM_LAYERS)); ACC_W = 2*WIDTH + $clog2(TAPS) + 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle layer start request
- layer_sel  in  LSEL_W  layer index, sampled with start
- layer_out  out  LSEL_W  latched active layer; drives external weight/bias mux
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last pixel is handed off
- ifm_valid  in  1  ifm_data valid
- ifm_ready  out  1  engine accepts a tap
- ifm_data  in  WIDTH  signed input sample, tap order: channel-major within window
- w_addr  out  $clog2(TAPS)  weight ROM address (= current tap index)
- w_data  in  CHOUT*WIDTH  combinational ROM output for w_addr; channel c at [c*WIDTH +: WIDTH]
- bias_data  in  CHOUT*2*WIDTH  per-layer bias, same scale as products
- ofm_valid  out  1  ofm_data holds a finished pixel
- ofm_ready  in  1  downstream accepts the pixel
- ofm_data  out  CHOUT*WIDTH  output pixel, all channels

Behaviour:
- Reset values: busy=0, done=0, ifm_ready=0, ofm_valid=0, ofm_data=0, layer_out=0, w_addr=0. Accumulators, tap counter and pixel counter are cleared. State is IDLE.
- States and transitions:
  - IDLE: start=1 latches layer_sel into layer_out, clears counters and accumulators, goes to ACCUM next cycle. layer_sel >= NUM_LAYERS is clamped to 0.
  - ACCUM: ifm_ready=1. Each tap handshake (ifm_valid && ifm_ready) adds signed ifm_data*w_data[c] to acc[c] and increments the tap counter. ifm_valid=0 stalls with no change. The handshake on tap TAPS-1 moves to OUT.
  - OUT (1 cycle): ifm_ready=0. For each c: s = acc[c] + sign-extended bias[c]; if s<0 the result is 0 (ReLU); else s>>>FRAC, saturated to 2^(WIDTH-1)-1. The result is registered to ofm_data. ofm_valid=1 and accumulators clear. Goes to HOLD.
  - HOLD: ofm_valid and ofm_data stay stable until ofm_ready. On handshake ofm_valid drops next cycle and the pixel counter increments. At pixel WOUT*WOUT-1 the next state is DONE; otherwise tap counter=0 and the next state is ACCUM.
  - DONE: done=1 for exactly one cycle, busy drops with it, next state is IDLE.
- Latency: the first ofm_valid appears 1 cycle after the last tap handshake. Back-to-back pixels cost TAPS+2 cycles minimum.
- w_addr equals the tap counter at all times. w_data is sampled in the same cycle as the tap handshake.
- start while busy is ignored, with no effect on layer_out or counters.
- ofm_ready while ofm_valid=0 is ignored.
- Mid-operation reset: everything returns to reset values immediately. No partial pixel is emitted.
- Arithmetic: products are 2*WIDTH signed; accumulators are ACC_W and cannot overflow for TAPS terms.
- Saturation also applies when the shifted result exceeds the WIDTH positive range.

Test Plan:
- Small config WOUT=2, CHIN=2, KDIM=3 (TAPS=18), FRAC=0. Inputs: layer_sel=1, all ifm=1, weights w[c]=c, bias=0, ofm_ready=1. Expect 4 pixels with ofm_data[c]=18*c, done pulse 1 cycle after the 4th handshake, layer_out=1 throughout.
- Stall/backpressure: ifm_valid toggled 50% and ofm_ready held low for 5 cycles per pixel. Expect results identical to test 1 and ofm_data stable while ofm_valid=1 && !ofm_ready.
- ReLU and saturation, WIDTH=16, FRAC=0: ifm=-1, w=1 gives channel output 0. ifm=16383, w=16383, bias=0 gives 32767.
- Fixed point, FRAC=14, TAPS=18: ifm=16384 (1.0), w=8192 (0.5), bias=0. Expect ofm=147456 saturated to 32767; with CHIN=1, KDIM=1, expect 8192.
- start asserted in mid-ACCUM with layer_sel=0 is ignored: layer_out stays 1 and the output count stays 4.
- rst low during pixel 2 HOLD: busy=0, ofm_valid=0 and ofm_data=0 immediately. A new start recomputes from pixel 0 with correct values.
